// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit-side arbitration logic.
package uart_pkg;

    localparam int NUM_REQ_MAX = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START   = 2'd1,
        WAIT_FI = 2'd2,
        GAP     = 2'd3
    } arb_state_e;

    // Down-counter width able to hold (v-1); a value of 0 or 1 still gets one bit.
    function automatic int cnt_width(input int v);
        return (v < 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin pick: rotate the request vector so that ptr sits
// at bit 0, take the lowest set bit, then rotate the index back.
module uart_rr_arbiter #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt_onehot,
    output logic [W-1:0] gnt_id,
    output logic         any
);

    localparam logic [W:0] N_L = (W+1)'(N);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [W-1:0]   enc;
    logic [W:0]     sum;

    // Rotate, priority-encode the lowest set bit, and map back to a requester index.
    always_comb begin
        dbl = {req, req} >> ptr;
        rot = dbl[N-1:0];
        enc = '0;
        any = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                enc = W'(i);
                any = 1'b1;
            end
        end
        sum = {1'b0, enc} + {1'b0, ptr};
        if (sum >= N_L) begin
            sum = sum - N_L;
        end
        gnt_id     = sum[W-1:0];
        gnt_onehot = any ? (N'(1) << gnt_id) : '0;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter between NUM_REQ byte
// producers, with optional inter-frame gap and transmitter watchdog.
// Optional feature macro: UART_TX_ARB_LOCK_EN (holds the grant on one
// requester until it delivers a byte flagged with req_last_i).
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | waiting for enable_i and a valid requester; accepts a byte
//   START   | start_tx_o pulse to the transmitter
//   WAIT_FI | frame in flight; watchdog running until trans_fi_i
//   GAP     | enforced idle time before the next grant
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int GAP_CYCLES     = 0,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable_i,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    input  logic [NUM_REQ*8-1:0]       req_data_i,
    input  logic [NUM_REQ-1:0]         req_last_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    output logic [7:0]                 data_o,
    output logic                       tx_en_o,
    output logic                       start_tx_o,
    input  logic                       trans_fi_i,
    output logic [$clog2(NUM_REQ)-1:0] grant_id_o,
    output logic                       busy_o,
    output logic                       timeout_o
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int GAP_W = cnt_width(GAP_CYCLES);
    localparam int TO_W  = cnt_width(TIMEOUT_CYCLES);
    localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;
    localparam logic [TO_W-1:0]  TO_LOAD  = (TIMEOUT_CYCLES > 0) ? TO_W'(TIMEOUT_CYCLES - 1) : '0;

    arb_state_e         state;
    logic [ID_W-1:0]    rr_ptr;
    logic [GAP_W-1:0]   gap_cnt;
    logic [TO_W-1:0]    to_cnt;
    logic [NUM_REQ-1:0] arb_req;
    logic [NUM_REQ-1:0] arb_onehot;
    logic [ID_W-1:0]    arb_id;
    logic               arb_any;
    logic               accept;
    logic               to_expire;
    logic [7:0]         sel_byte;

    function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] g);
        return (int'(g) == NUM_REQ - 1) ? '0 : g + 1'b1;
    endfunction

`ifdef UART_TX_ARB_LOCK_EN
    logic locked;
    logic cur_last;

    // While locked only the currently granted requester may compete.
    always_comb begin
        arb_req = locked ? (req_valid_i & (NUM_REQ'(1) << grant_id_o)) : req_valid_i;
    end
`else
    logic unused_last;

    assign arb_req     = req_valid_i;
    assign unused_last = ^req_last_i;
`endif

    uart_rr_arbiter #(
        .N (NUM_REQ),
        .W (ID_W)
    ) u_rr (
        .req        (arb_req),
        .ptr        (rr_ptr),
        .gnt_onehot (arb_onehot),
        .gnt_id     (arb_id),
        .any        (arb_any)
    );

    assign accept      = (state == IDLE) && enable_i && arb_any && !reset;
    assign req_ready_o = accept ? arb_onehot : '0;
    assign to_expire   = (TIMEOUT_CYCLES != 0) && (to_cnt == '0);

    // Byte offered by the requester that wins this cycle.
    always_comb begin
        sel_byte = req_data_i[8*int'(arb_id) +: 8];
    end

    // Sequencer: grant, start pulse, frame wait with watchdog, gap.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            data_o     <= 8'h00;
            grant_id_o <= '0;
            tx_en_o    <= 1'b0;
            start_tx_o <= 1'b0;
            busy_o     <= 1'b0;
            timeout_o  <= 1'b0;
            gap_cnt    <= '0;
            to_cnt     <= '0;
`ifdef UART_TX_ARB_LOCK_EN
            locked     <= 1'b0;
            cur_last   <= 1'b0;
`endif
        end else begin
            start_tx_o <= 1'b0;
            timeout_o  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        data_o     <= sel_byte;
                        grant_id_o <= arb_id;
                        start_tx_o <= 1'b1;
                        tx_en_o    <= 1'b1;
                        busy_o     <= 1'b1;
                        state      <= START;
`ifdef UART_TX_ARB_LOCK_EN
                        locked     <= 1'b1;
                        cur_last   <= req_last_i[arb_id];
`else
                        rr_ptr     <= next_ptr(arb_id);
`endif
                    end
                end
                START: begin
                    to_cnt <= TO_LOAD;
                    state  <= WAIT_FI;
                end
                WAIT_FI: begin
                    if (trans_fi_i || to_expire) begin
                        tx_en_o   <= 1'b0;
                        timeout_o <= !trans_fi_i;
`ifdef UART_TX_ARB_LOCK_EN
                        if (cur_last) begin
                            locked <= 1'b0;
                            rr_ptr <= next_ptr(grant_id_o);
                        end
`endif
                        if (GAP_CYCLES == 0) begin
                            busy_o <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            gap_cnt <= GAP_LOAD;
                            state   <= GAP;
                        end
                    end else if (TIMEOUT_CYCLES != 0) begin
                        to_cnt <= to_cnt - 1'b1;
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter. Instance a: GAP 0, watchdog 20.
// Instance b: GAP 5, no watchdog.
module tb_uart_tx_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        en_a, en_b, fi_a, fi_b;
    logic [3:0]  val_a, val_b, last_a, last_b, rdy_a, rdy_b;
    logic [31:0] dat_a, dat_b;
    logic [7:0]  do_a, do_b;
    logic        txen_a, txen_b, st_a, st_b, busy_a, busy_b, to_a, to_b;
    logic [1:0]  gid_a, gid_b;

    int n_cmp = 0;
    int n_err = 0;
    int mptr  = 0;

    uart_tx_arbiter #(.NUM_REQ(4), .GAP_CYCLES(0), .TIMEOUT_CYCLES(20)) dut_a (
        .clk(clk), .reset(reset), .enable_i(en_a), .req_valid_i(val_a),
        .req_data_i(dat_a), .req_last_i(last_a), .req_ready_o(rdy_a),
        .data_o(do_a), .tx_en_o(txen_a), .start_tx_o(st_a), .trans_fi_i(fi_a),
        .grant_id_o(gid_a), .busy_o(busy_a), .timeout_o(to_a)
    );

    uart_tx_arbiter #(.NUM_REQ(4), .GAP_CYCLES(5), .TIMEOUT_CYCLES(0)) dut_b (
        .clk(clk), .reset(reset), .enable_i(en_b), .req_valid_i(val_b),
        .req_data_i(dat_b), .req_last_i(last_b), .req_ready_o(rdy_b),
        .data_o(do_b), .tx_en_o(txen_b), .start_tx_o(st_b), .trans_fi_i(fi_b),
        .grant_id_o(gid_b), .busy_o(busy_b), .timeout_o(to_b)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference rule: first valid requester searching upward from p, modulo 4.
    function automatic int exp_grant(input logic [3:0] m, input int p);
        for (int i = 0; i < 4; i++) begin
            if (m[(p + i) % 4]) return (p + i) % 4;
        end
        return -1;
    endfunction

    task automatic do_reset;
        reset = 1'b1;
        en_a = 1'b0; en_b = 1'b0;
        val_a = '0; val_b = '0;
        fi_a = 1'b0; fi_b = 1'b0;
        last_a = 4'hF; last_b = 4'hF;
        dat_a = '0; dat_b = '0;
        tick;
        tick;
        reset = 1'b0;
        mptr = 0;
        #1;
    endtask

    task automatic test_reset;
        do_reset;
        n_cmp++;
        if ({do_a, gid_a, busy_a, st_a, txen_a, to_a} !== 14'h0) begin
            n_err++;
            $display("FAIL reset_a_outputs: got %h want 0", {do_a, gid_a, busy_a, st_a, txen_a, to_a});
        end
        n_cmp++;
        if ({do_b, gid_b, busy_b, st_b, txen_b, to_b} !== 14'h0) begin
            n_err++;
            $display("FAIL reset_b_outputs: got %h want 0", {do_b, gid_b, busy_b, st_b, txen_b, to_b});
        end
        n_cmp++;
        if (rdy_a !== 4'h0) begin
            n_err++;
            $display("FAIL reset_ready: got %b want 0000", rdy_a);
        end
    endtask

    task automatic test_single;
        en_a = 1'b1;
        dat_a = 32'h00A5_0000;
        val_a = 4'b0100;
        #1;
        n_cmp++;
        if (rdy_a !== 4'b0100) begin
            n_err++; $display("FAIL single_ready: got %b want 0100", rdy_a);
        end
        tick;
        val_a = 4'b0000;
        #1;
        n_cmp++;
        if ({st_a, txen_a, gid_a, do_a} !== {1'b1, 1'b1, 2'd2, 8'hA5}) begin
            n_err++;
            $display("FAIL single_start: got st=%b en=%b id=%0d data=%h want 1 1 2 a5", st_a, txen_a, gid_a, do_a);
        end
        tick;
        n_cmp++;
        if ({st_a, txen_a, busy_a} !== 3'b011) begin
            n_err++; $display("FAIL single_wait: got st/en/busy=%b want 011", {st_a, txen_a, busy_a});
        end
        fi_a = 1'b1;
        tick;
        fi_a = 1'b0;
        n_cmp++;
        if ({busy_a, txen_a, to_a} !== 3'b000) begin
            n_err++; $display("FAIL single_done: got busy/en/to=%b want 000", {busy_a, txen_a, to_a});
        end
    endtask

    task automatic test_round_robin;
        int exp;
        int c;
        do_reset;
        en_a = 1'b1;
        dat_a = 32'h4433_2211;
        val_a = 4'hF;
        #1;
        for (int f = 0; f < 8; f++) begin
            c = 0;
            while (rdy_a == 4'h0 && c < 4) begin
                tick;
                c++;
            end
            exp = exp_grant(val_a, mptr);
            mptr = (exp + 1) % 4;
            n_cmp++;
            if (rdy_a !== 4'(1 << exp)) begin
                n_err++; $display("FAIL rr_ready frame %0d: got %b want grant %0d", f, rdy_a, exp);
            end
            tick;
            n_cmp++;
            if (gid_a !== 2'(exp) || do_a !== dat_a[8*exp +: 8]) begin
                n_err++; $display("FAIL rr_grant frame %0d: got id=%0d data=%h want %0d %h", f, gid_a, do_a, exp, dat_a[8*exp +: 8]);
            end
            tick;
            fi_a = 1'b1;
            tick;
            fi_a = 1'b0;
            #1;
        end
        val_a = 4'h0;
    endtask

    task automatic test_timeout;
        int hit;
        do_reset;
        en_a = 1'b1;
        dat_a = $urandom;
        val_a = 4'b0011;
        #1;
        n_cmp++;
        if (rdy_a !== 4'b0001) begin
            n_err++; $display("FAIL to_first_ready: got %b want 0001", rdy_a);
        end
        tick;
        val_a = 4'b0010;
        tick;
        hit = -1;
        for (int k = 1; k <= 25; k++) begin
            tick;
            if (to_a === 1'b1) begin
                hit = k;
                break;
            end
        end
        n_cmp++;
        if (hit !== 20) begin
            n_err++; $display("FAIL to_latency: got %0d cycles want 20", hit);
        end
        n_cmp++;
        if (txen_a !== 1'b0 || rdy_a !== 4'b0010) begin
            n_err++; $display("FAIL to_next_grant: got en=%b ready=%b want 0 0010", txen_a, rdy_a);
        end
        tick;
        val_a = 4'b0000;
        n_cmp++;
        if (gid_a !== 2'd1 || st_a !== 1'b1) begin
            n_err++; $display("FAIL to_regrant: got id=%0d st=%b want 1 1", gid_a, st_a);
        end
        tick;
        repeat (19) tick;
        fi_a = 1'b1;
        tick;
        fi_a = 1'b0;
        n_cmp++;
        if (to_a !== 1'b0 || busy_a !== 1'b0) begin
            n_err++; $display("FAIL to_tie: got to=%b busy=%b want 0 0", to_a, busy_a);
        end
    endtask

    task automatic test_gap;
        int first;
        do_reset;
        en_b = 1'b1;
        dat_b = $urandom;
        val_b = 4'b0011;
        #1;
        n_cmp++;
        if (rdy_b !== 4'b0001) begin
            n_err++; $display("FAIL gap_first_ready: got %b want 0001", rdy_b);
        end
        tick;
        val_b = 4'b0010;
        tick;
        fi_b = 1'b1;
        tick;
        fi_b = 1'b0;
        n_cmp++;
        if (busy_b !== 1'b1 || txen_b !== 1'b0) begin
            n_err++; $display("FAIL gap_busy: got busy=%b en=%b want 1 0", busy_b, txen_b);
        end
        first = -1;
        for (int k = 1; k <= 10; k++) begin
            #1;
            if (rdy_b != 4'h0) begin
                first = k;
                break;
            end
            tick;
        end
        n_cmp++;
        if (first !== 6 || rdy_b !== 4'b0010) begin
            n_err++; $display("FAIL gap_next_ready: got cycle F+%0d ready=%b want F+6 0010", first, rdy_b);
        end
        tick;
        val_b = 4'b0000;
    endtask

    task automatic test_enable;
        int bad;
        do_reset;
        en_a = 1'b1;
        val_a = 4'b0011;
        dat_a = $urandom;
        #1;
        n_cmp++;
        if (rdy_a !== 4'b0001) begin
            n_err++; $display("FAIL en_first_ready: got %b want 0001", rdy_a);
        end
        tick;
        val_a = 4'b0010;
        tick;
        en_a = 1'b0;
        tick;
        tick;
        n_cmp++;
        if (txen_a !== 1'b1 || busy_a !== 1'b1) begin
            n_err++; $display("FAIL en_inflight: got en=%b busy=%b want 1 1", txen_a, busy_a);
        end
        fi_a = 1'b1;
        tick;
        fi_a = 1'b0;
        bad = 0;
        repeat (5) begin
            if (rdy_a !== 4'h0 || busy_a !== 1'b0) bad++;
            tick;
        end
        n_cmp++;
        if (bad !== 0) begin
            n_err++; $display("FAIL en_blocked: got %0d granting cycles want 0", bad);
        end
        en_a = 1'b1;
        #1;
        n_cmp++;
        if (rdy_a !== 4'b0010) begin
            n_err++; $display("FAIL en_resume_ready: got %b want 0010", rdy_a);
        end
        tick;
        val_a = 4'b0000;
        tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({do_a, gid_a, busy_a, st_a, txen_a, to_a, rdy_a} !== 18'h0) begin
            n_err++; $display("FAIL midframe_reset: got %h want 0", {do_a, gid_a, busy_a, st_a, txen_a, to_a, rdy_a});
        end
        val_a = 4'hF;
        #1;
        n_cmp++;
        if (rdy_a !== 4'b0001) begin
            n_err++; $display("FAIL reset_ptr: got %b want 0001", rdy_a);
        end
        val_a = 4'h0;
        mptr = 0;
        #1;
    endtask

    task automatic test_random;
        logic [3:0] mask;
        int exp;
        int d;
        do_reset;
        en_a = 1'b1;
        for (int f = 0; f < 40; f++) begin
            mask = 4'($urandom_range(0, 15));
            dat_a = $urandom;
            val_a = mask;
            #1;
            if (mask == 4'h0) begin
                n_cmp++;
                if (rdy_a !== 4'h0) begin
                    n_err++; $display("FAIL rand_idle frame %0d: got %b want 0000", f, rdy_a);
                end
                tick;
                continue;
            end
            exp = exp_grant(mask, mptr);
            mptr = (exp + 1) % 4;
            n_cmp++;
            if (rdy_a !== 4'(1 << exp)) begin
                n_err++; $display("FAIL rand_ready frame %0d: got %b want grant %0d", f, rdy_a, exp);
            end
            tick;
            val_a = 4'h0;
            n_cmp++;
            if (st_a !== 1'b1 || gid_a !== 2'(exp) || do_a !== dat_a[8*exp +: 8]) begin
                n_err++; $display("FAIL rand_start frame %0d: got st=%b id=%0d data=%h want 1 %0d %h", f, st_a, gid_a, do_a, exp, dat_a[8*exp +: 8]);
            end
            tick;
            if ($urandom_range(0, 3) == 0) begin
                repeat (20) tick;
                n_cmp++;
                if (to_a !== 1'b1 || txen_a !== 1'b0) begin
                    n_err++; $display("FAIL rand_timeout frame %0d: got to=%b en=%b want 1 0", f, to_a, txen_a);
                end
            end else begin
                d = $urandom_range(0, 19);
                repeat (d) tick;
                fi_a = 1'b1;
                tick;
                fi_a = 1'b0;
                n_cmp++;
                if (to_a !== 1'b0 || busy_a !== 1'b0) begin
                    n_err++; $display("FAIL rand_done frame %0d delay %0d: got to=%b busy=%b want 0 0", f, d, to_a, busy_a);
                end
            end
        end
        val_a = 4'h0;
    endtask

`ifdef UART_TX_ARB_LOCK_EN
    task automatic test_lock;
        int seq [4] = '{1, 1, 1, 0};
        do_reset;
        en_a = 1'b1;
        dat_a = $urandom;
        for (int i = 0; i < 4; i++) begin
            last_a = (i == 2) ? 4'b0010 : 4'b0000;
            val_a = (i == 0) ? 4'b0010 : ((i < 3) ? 4'b0011 : 4'b0001);
            #1;
            n_cmp++;
            if (rdy_a !== 4'(1 << seq[i])) begin
                n_err++; $display("FAIL lock_ready byte %0d: got %b want grant %0d", i, rdy_a, seq[i]);
            end
            tick;
            val_a = 4'h0;
            tick;
            fi_a = 1'b1;
            tick;
            fi_a = 1'b0;
        end
        last_a = 4'hF;
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_single;
        test_round_robin;
        test_timeout;
        test_gap;
        test_enable;
        test_random;
`ifdef UART_TX_ARB_LOCK_EN
        test_lock;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
